// File: rtl/mdpath_hs.sv
// mdpath_hs: multi-cycle MIPS datapath with a req/ready memory handshake,
// sub-word load/store lane steering and a parametrised reset vector.
module mdpath_hs #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter bit          SUBWORD_EN  = 1'b1,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IorD,
  input  logic        IRWrite,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  LSSize,
  input  logic        LSUnsigned,
  input  logic [1:0]  RegDst,
  input  logic        RegWrite,
  input  logic [1:0]  MemtoReg,
  input  logic        ALUSrcA,
  input  logic [1:0]  ALUSrcB,
  input  logic [1:0]  PCSource,
  input  logic        PCWrite,
  input  logic        PCWriteCond,
  input  logic        Branch,
  input  logic [2:0]  ALU_operation,
  input  logic [31:0] data2CPU,
  input  logic        MIO_ready,
  output logic [31:0] M_addr,
  output logic [31:0] data_out,
  output logic [3:0]  byte_en,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        mem_busy,
  output logic        mem_done,
  output logic        misaligned,
  output logic [31:0] PC_Current,
  output logic [31:0] Inst,
  output logic        zero,
  output logic        overflow
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_mdr;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_aluout;
  logic [31:0] r_rf [32];
  logic [31:0] r_maddr;
  logic [31:0] r_dout;
  logic [3:0]  r_be;
  logic        r_rd;
  logic        r_wr;
  logic        r_done;
  logic        r_mis;
  logic        r_fetch;
  logic        r_uns;
  logic [1:0]  r_size;

  logic        w_busy;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_wa;
  logic [31:0] w_imm;
  logic [31:0] w_wd;
  logic [31:0] w_src_a;
  logic [31:0] w_src_b;
  logic [31:0] w_res;
  logic        w_ovf;
  logic        w_zero;
  logic [31:0] w_pc_next;
  logic        w_pc_we;
  logic [1:0]  w_size;
  logic        w_byte;
  logic        w_half;
  logic        w_word;
  logic        w_mis;
  logic [31:0] w_araw;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;
  logic [7:0]  w_lb;
  logic [15:0] w_lh;
  logic [31:0] w_ld;

  assign w_busy = (r_state == S_BUSY);
  assign w_rs   = r_ir[25:21];
  assign w_rt   = r_ir[20:16];
  assign w_rd   = r_ir[15:11];
  assign w_imm  = {{16{r_ir[15]}}, r_ir[15:0]};

  always_comb begin
    case (RegDst)
      2'b01:   w_wa = w_rd;
      2'b10:   w_wa = 5'd31;
      default: w_wa = w_rt;
    endcase
  end

  always_comb begin
    case (MemtoReg)
      2'b01:   w_wd = r_mdr;
      2'b10:   w_wd = {r_ir[15:0], 16'h0000};
      2'b11:   w_wd = r_pc;
      default: w_wd = r_aluout;
    endcase
  end

  assign w_src_a = ALUSrcA ? r_a : r_pc;

  always_comb begin
    case (ALUSrcB)
      2'b01:   w_src_b = 32'd4;
      2'b10:   w_src_b = w_imm;
      2'b11:   w_src_b = {w_imm[29:0], 2'b00};
      default: w_src_b = r_b;
    endcase
  end

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (ALU_operation)
      3'b000: w_res = w_src_a & w_src_b;
      3'b001: w_res = w_src_a | w_src_b;
      3'b010: begin
        w_res = w_src_a + w_src_b;
        w_ovf = (w_src_a[31] == w_src_b[31]) &
                (w_res[31] != w_src_a[31]);
      end
      3'b011: w_res = w_src_a ^ w_src_b;
      3'b100: w_res = ~(w_src_a | w_src_b);
      3'b101: w_res = w_src_b >> r_ir[10:6];
      3'b110: begin
        w_res = w_src_a - w_src_b;
        w_ovf = (w_src_a[31] != w_src_b[31]) &
                (w_res[31] != w_src_a[31]);
      end
      default: w_res = {31'd0, $signed(w_src_a) < $signed(w_src_b)};
    endcase
  end

  assign w_zero = (w_res == 32'd0);

  always_comb begin
    case (PCSource)
      2'b01:   w_pc_next = r_aluout;
      2'b10:   w_pc_next = {r_pc[31:28], r_ir[25:0], 2'b00};
      2'b11:   w_pc_next = r_a;
      default: w_pc_next = w_res;
    endcase
  end

  // Branch selects the sense: beq takes on zero, bne on !zero.
  assign w_pc_we = (PCWrite | (PCWriteCond & (w_zero == Branch))) & ~w_busy;

  assign w_size = SUBWORD_EN ? LSSize : 2'b00;
  assign w_byte = (w_size == 2'b10);
  assign w_half = (w_size == 2'b01);
  assign w_word = ~w_byte & ~w_half;
  assign w_araw = IorD ? r_aluout : r_pc;
  assign w_mis  = (w_half & w_araw[0]) | (w_word & (w_araw[1:0] != 2'b00));

  always_comb begin
    w_addr  = {w_araw[31:2], 2'b00};
    w_be    = 4'b1111;
    w_wdata = r_b;
    unique case (1'b1)
      w_byte: begin
        w_addr  = w_araw;
        w_be    = 4'b0001 << w_araw[1:0];
        w_wdata = {4{r_b[7:0]}};
      end
      w_half: begin
        w_addr  = {w_araw[31:1], 1'b0};
        w_be    = w_araw[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{r_b[15:0]}};
      end
      w_word: begin
        w_addr  = {w_araw[31:2], 2'b00};
        w_be    = 4'b1111;
        w_wdata = r_b;
      end
    endcase
  end

  // Little-endian lane select for sub-word loads.
  always_comb begin
    case (r_maddr[1:0])
      2'b01:   w_lb = data2CPU[15:8];
      2'b10:   w_lb = data2CPU[23:16];
      2'b11:   w_lb = data2CPU[31:24];
      default: w_lb = data2CPU[7:0];
    endcase
    w_lh = r_maddr[1] ? data2CPU[31:16] : data2CPU[15:0];
    w_ld = data2CPU;
    if (r_size == 2'b10)
      w_ld = {{24{~r_uns & w_lb[7]}}, w_lb};
    else if (r_size == 2'b01)
      w_ld = {{16{~r_uns & w_lh[15]}}, w_lh};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
      for (int i = 0; i < 32; i++)
        r_rf[i] <= '0;
    end else begin
      if (w_pc_we)
        r_pc <= w_pc_next;
      if (!w_busy) begin
        r_a      <= r_rf[w_rs];
        r_b      <= r_rf[w_rt];
        r_aluout <= w_res;
      end
      if (RegWrite && (w_wa != 5'd0))
        r_rf[w_wa] <= w_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
      r_mdr   <= '0;
      r_maddr <= '0;
      r_dout  <= '0;
      r_be    <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_done  <= 1'b0;
      r_mis   <= 1'b0;
      r_fetch <= 1'b0;
      r_uns   <= 1'b0;
      r_size  <= 2'b00;
    end else begin
      r_done <= 1'b0;
      r_mis  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (MemRead | MemWrite) begin
            if (ALIGN_CHECK && w_mis) begin
              r_mis <= 1'b1;
            end else begin
              r_state <= S_BUSY;
              r_maddr <= w_addr;
              r_rd    <= MemRead;
              r_wr    <= ~MemRead;
              r_fetch <= MemRead & IRWrite;
              r_uns   <= LSUnsigned;
              r_size  <= w_size;
              r_be    <= MemRead ? 4'b0000 : w_be;
              if (!MemRead)
                r_dout <= w_wdata;
            end
          end
        end
        S_BUSY: begin
          if (MIO_ready) begin
            r_state <= S_IDLE;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_be    <= 4'b0000;
            r_done  <= 1'b1;
            if (r_rd) begin
              if (r_fetch)
                r_ir <= data2CPU;
              else
                r_mdr <= w_ld;
            end
          end
        end
      endcase
    end
  end

  assign M_addr     = r_maddr;
  assign data_out   = r_dout;
  assign byte_en    = r_be;
  assign mem_rd     = r_rd;
  assign mem_wr     = r_wr;
  assign mem_busy   = w_busy;
  assign mem_done   = r_done;
  assign misaligned = r_mis;
  assign PC_Current = r_pc;
  assign Inst       = r_ir;
  assign zero       = w_zero;
  assign overflow   = w_ovf;

endmodule
